// File: rtl/test_00_stim.sv
// Stimulus/response driver for the 3-input registered test slice: LFSR vectors, reference model, error count.
// Optional first-mismatch capture ports are built when TEST_00_STIM_FIRST_ERR_EN is defined.
module test_00_stim #(
  parameter int          NUM_VECTORS = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_drv_rst_n,
  output logic             o_drv_a,
  output logic             o_drv_b,
  output logic             o_drv_c,
  input  logic             i_mon_a,
  input  logic             i_mon_b,
  input  logic [1:0]       i_mon_c
`ifdef TEST_00_STIM_FIRST_ERR_EN
  ,
  output logic             o_first_err_vld,
  output logic [15:0]      o_first_err_idx,
  output logic [3:0]       o_first_err_bits
`endif
);

  localparam int              RC_W     = $clog2(NUM_VECTORS + 1);
  localparam logic [15:0]     SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [RC_W-1:0] LAST_VEC = RC_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RC_W-1:0]  r_cnt;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_nxt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] w_err_nxt;
  logic             r_pass;
  logic             r_drv_rst_n;
  logic             r_exp_a;
  logic             r_exp_b;
  logic [1:0]       r_exp_c;
  logic             w_run;
  logic             w_start;
  logic             w_cmp_en;
  logic [3:0]       w_diff;
  logic             w_mis;
  logic             w_drv_a;
  logic             w_drv_b;
  logic             w_drv_c;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RESET;
      S_RESET: if (r_cnt == RC_W'(1)) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST_VEC) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run      = (r_state == S_RUN);
  assign w_start    = (r_state == S_IDLE) && i_start;
  assign w_drv_a    = w_run & r_lfsr[0];
  assign w_drv_b    = w_run & r_lfsr[1];
  assign w_drv_c    = w_run & r_lfsr[2];
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // Slice outputs lag the drives by one cycle, so vector k is checked in the cycle after it is driven.
  assign w_cmp_en  = (w_run && (r_cnt != '0)) || (r_state == S_DRAIN);
  assign w_diff    = {i_mon_a, i_mon_b, i_mon_c} ^ {r_exp_a, r_exp_b, r_exp_c};
  assign w_mis     = w_cmp_en && (w_diff != 4'd0);
  assign w_err_nxt = (w_mis && (r_err_cnt != '1)) ? r_err_cnt + CNT_W'(1) : r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_lfsr      <= SEED_EFF;
      r_err_cnt   <= '0;
      r_pass      <= 1'b0;
      r_drv_rst_n <= 1'b0;
      r_exp_a     <= 1'b0;
      r_exp_b     <= 1'b0;
      r_exp_c     <= 2'b00;
    end else begin
      r_drv_rst_n <= (w_state_nxt != S_RESET);

      case (r_state)
        S_IDLE:  r_cnt <= '0;
        S_RESET: r_cnt <= (r_cnt == RC_W'(1)) ? '0 : r_cnt + RC_W'(1);
        S_RUN:   r_cnt <= r_cnt + RC_W'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_start) begin
        r_lfsr    <= SEED_EFF;
        r_err_cnt <= '0;
        r_pass    <= 1'b0;
        r_exp_a   <= 1'b0;
        r_exp_b   <= 1'b0;
        r_exp_c   <= 2'b00;
      end else begin
        if (w_run) begin
          r_lfsr           <= w_lfsr_nxt;
          r_exp_a          <= w_drv_a;
          r_exp_b          <= w_drv_b;
          r_exp_c[w_drv_c] <= ~w_drv_c & ~w_drv_a;
        end
        r_err_cnt <= w_err_nxt;
        if (r_state == S_DRAIN) r_pass <= (w_err_nxt == '0);
      end
    end
  end

`ifdef TEST_00_STIM_FIRST_ERR_EN
  logic        r_fe_vld;
  logic [15:0] r_fe_idx;
  logic [3:0]  r_fe_bits;
  logic [15:0] w_cmp_idx;

  // r_cnt has already advanced past the vector under comparison.
  assign w_cmp_idx = 16'(r_cnt) - 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_start) begin
      r_fe_vld  <= 1'b0;
      r_fe_idx  <= '0;
      r_fe_bits <= '0;
    end else if (w_mis && !r_fe_vld) begin
      r_fe_vld  <= 1'b1;
      r_fe_idx  <= w_cmp_idx;
      r_fe_bits <= w_diff;
    end
  end

  assign o_first_err_vld  = r_fe_vld;
  assign o_first_err_idx  = r_fe_idx;
  assign o_first_err_bits = r_fe_bits;
`endif

  assign o_busy      = (r_state == S_RESET) || w_run || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);
  assign o_pass      = r_pass;
  assign o_err_cnt   = r_err_cnt;
  assign o_drv_rst_n = r_drv_rst_n;
  assign o_drv_a     = w_drv_a;
  assign o_drv_b     = w_drv_b;
  assign o_drv_c     = w_drv_c;

endmodule

// File: tb/tb_test_00_stim.sv
// Bench for test_00_stim: a registered slice model with selectable faults sits behind each driver instance.
// Build with TEST_00_STIM_FIRST_ERR_EN defined to also check the first-mismatch capture ports.
module tb_test_00_stim;

  localparam int N8 = 8;
  localparam int NS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst, start, start_s;
  int   fault;
  int   n_run  = 0;
  int   n_fail = 0;

  // Instance under main test: NUM_VECTORS=8, CNT_W=16
  logic        busy, done, pass, drst_n, da, db, dc, ma, mb;
  logic [15:0] err;
  logic [1:0]  mc;
  // Saturation instance: NUM_VECTORS=16, CNT_W=2
  logic        busy_s, done_s, pass_s, drst_n_s, da_s, db_s, dc_s, ma_s, mb_s;
  logic [1:0]  err_s;
  logic [1:0]  mc_s;
`ifdef TEST_00_STIM_FIRST_ERR_EN
  logic        fe_vld, fe_vld_s;
  logic [15:0] fe_idx, fe_idx_s;
  logic [3:0]  fe_bits, fe_bits_s;
`endif

  test_00_stim #(.NUM_VECTORS(N8), .LFSR_SEED(16'hACE1), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err),
    .o_drv_rst_n(drst_n), .o_drv_a(da), .o_drv_b(db), .o_drv_c(dc),
    .i_mon_a(ma), .i_mon_b(mb), .i_mon_c(mc)
`ifdef TEST_00_STIM_FIRST_ERR_EN
    , .o_first_err_vld(fe_vld), .o_first_err_idx(fe_idx), .o_first_err_bits(fe_bits)
`endif
  );

  test_00_stim #(.NUM_VECTORS(NS), .LFSR_SEED(16'hACE1), .CNT_W(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start_s),
    .o_busy(busy_s), .o_done(done_s), .o_pass(pass_s), .o_err_cnt(err_s),
    .o_drv_rst_n(drst_n_s), .o_drv_a(da_s), .o_drv_b(db_s), .o_drv_c(dc_s),
    .i_mon_a(ma_s), .i_mon_b(mb_s), .i_mon_c(mc_s)
`ifdef TEST_00_STIM_FIRST_ERR_EN
    , .o_first_err_vld(fe_vld_s), .o_first_err_idx(fe_idx_s), .o_first_err_bits(fe_bits_s)
`endif
  );

  // Target slices: registered, cleared while their reset is low.
  logic       ta, tb_q, ta_s, tb_s;
  logic [1:0] tc, tc_s;

  always_ff @(posedge clk) begin
    if (!drst_n) begin
      ta <= 1'b0; tb_q <= 1'b0; tc <= 2'b00;
    end else begin
      ta <= da; tb_q <= db; tc[dc] <= !dc && !da;
    end
  end

  always_ff @(posedge clk) begin
    if (!drst_n_s) begin
      ta_s <= 1'b0; tb_s <= 1'b0; tc_s <= 2'b00;
    end else begin
      ta_s <= da_s; tb_s <= db_s; tc_s[dc_s] <= !dc_s && !da_s;
    end
  end

  assign ma   = ta;
  assign mb   = (fault == 1) ? 1'b0 : tb_q;
  assign mc   = (fault == 2) ? {1'b1, tc[0]} : tc;
  assign ma_s = ~ta_s;
  assign mb_s = tb_s;
  assign mc_s = tc_s;

  typedef struct {
    string      name;
    int         fault;
    int         restart_j;
    int         exp_err;
    bit         exp_pass;
    bit         exp_fvld;
    int         exp_fidx;
    logic [3:0] exp_fbits;
  } run_t;

  run_t        runs[4];
  logic [15:0] vec[NS];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one run on the 8-vector instance and checks every cycle until it is back in IDLE.
  task automatic run8(input run_t r);
    int dones;
    dones = 0;
    fault = r.fault;
    start = 1'b1;
    tick();
    for (int j = 0; j < N8 + 5; j++) begin
      start = (j == r.restart_j);
      dones += int'(done);
      check($sformatf("%s.rst_n@%0d", r.name, j), drst_n, (j >= 2));
      if (j >= 2 && j < N8 + 2)
        check($sformatf("%s.drv@%0d", r.name, j), {dc, db, da}, vec[j-2][2:0]);
      else
        check($sformatf("%s.drv@%0d", r.name, j), {dc, db, da}, 3'b000);
      check($sformatf("%s.busy@%0d", r.name, j), busy, (j < N8 + 3));
      check($sformatf("%s.done@%0d", r.name, j), done, (j == N8 + 3));
      if (j >= N8 + 3) begin
        check($sformatf("%s.err@%0d", r.name, j), err, r.exp_err);
        check($sformatf("%s.pass@%0d", r.name, j), pass, r.exp_pass);
`ifdef TEST_00_STIM_FIRST_ERR_EN
        check($sformatf("%s.fe_vld@%0d", r.name, j), fe_vld, r.exp_fvld);
        if (r.exp_fvld) begin
          check($sformatf("%s.fe_idx", r.name), fe_idx, r.exp_fidx);
          check($sformatf("%s.fe_bits", r.name), fe_bits, r.exp_fbits);
        end
`endif
      end
      tick();
    end
    start = 1'b0;
    check($sformatf("%s.done_pulses", r.name), dones, 1);
  endtask

  initial begin
    int nb, first_b, dones, k;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; fault = 0;

    vec[0] = 16'hACE1;
    for (int i = 1; i < NS; i++) vec[i] = lfsr_step(vec[i-1]);
    nb = 0; first_b = -1;
    for (int i = 0; i < N8; i++) begin
      if (vec[i][1]) begin
        nb++;
        if (first_b < 0) first_b = i;
      end
    end

    runs[0] = '{"clean",           0, -1, 0,  1'b1,       1'b0,       0,       4'b0000};
    runs[1] = '{"b_stuck0",        1, -1, nb, (nb == 0),  (nb != 0),  first_b, 4'b0100};
    runs[2] = '{"restart_ignored", 0,  4, 0,  1'b1,       1'b0,       0,       4'b0000};
    runs[3] = '{"c1_stuck1",       2, -1, N8, 1'b0,       1'b1,       0,       4'b0010};

    tick(); tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.err", err, 0);
    check("rst.rst_n", drst_n, 0);
    check("rst.drv", {da, db, dc}, 3'b000);
    check("rst.sat_err", err_s, 0);
    rst = 1'b0;
    tick();
    check("idle.rst_n", drst_n, 1);
    check("idle.busy", busy, 0);

    // Start sampled at edge 10.
    while (cyc < 9) tick();
    for (int i = 0; i < 4; i++) run8(runs[i]);

    // Reset during RUN cycle 4 aborts the run without a done pulse.
    fault = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort.busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.err", err, 0);
    check("abort.rst_n", drst_n, 0);
    check("abort.done", done, 0);
    check("abort.drv", {da, db, dc}, 3'b000);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      dones += int'(done);
    end
    check("abort.no_done", dones, 0);
    check("abort.idle", busy, 0);
    run8(runs[0]);

    // Saturating 2-bit counter with target output a inverted.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    k = 0;
    while (k < 60 && !done_s) begin
      tick();
      k++;
    end
    check("sat.done_seen", done_s, 1);
    check("sat.done_cycle", k, NS + 3);
    check("sat.err", err_s, 2'b11);
    check("sat.pass", pass_s, 0);
`ifdef TEST_00_STIM_FIRST_ERR_EN
    check("sat.fe_vld", fe_vld_s, 1);
    check("sat.fe_idx", fe_idx_s, 0);
    check("sat.fe_bits", fe_bits_s, 4'b1000);
`endif
    tick();
    check("sat.idle", busy_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
